// File: rtl/sync_counter_pkg.sv
// ---------------------------------------------------------------------------
// sync_counter_pkg
// Shared defaults for the constant-multiplier register block.
//   WIDTH_DEF   default operand / result width
//   FACTOR_DEF  default constant multiplier
//   prod_width  full-precision product width for a given operand width
// ---------------------------------------------------------------------------
package sync_counter_pkg;

  localparam int WIDTH_DEF  = 4;
  localparam int FACTOR_DEF = 2;

  // A WIDTH x WIDTH unsigned product never needs more than 2*WIDTH bits.
  function automatic int prod_width(input int width);
    return 2 * width;
  endfunction

  localparam int PROD_W_DEF = prod_width(WIDTH_DEF);

endpackage

// File: rtl/sync_counter_const_mult.sv
// ---------------------------------------------------------------------------
// const_mult
// Purely combinational unsigned multiply by a compile-time constant.
// Ports:
//   i_data  [WIDTH-1:0]    unsigned operand
//   o_prod  [2*WIDTH-1:0]  full-precision product i_data * FACTOR
// Parameters: WIDTH, FACTOR (0 .. 2^WIDTH-1)
// ---------------------------------------------------------------------------
module const_mult
  import sync_counter_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int FACTOR = FACTOR_DEF
) (
  input  logic [WIDTH-1:0]             i_data,
  output logic [prod_width(WIDTH)-1:0] o_prod
);

  localparam int PW = prod_width(WIDTH);
  localparam logic [WIDTH-1:0] FACTOR_BITS = WIDTH'(FACTOR);

  logic [PW-1:0] w_sum;

  // Shift-and-add over the set bits of the constant; clear bits of FACTOR
  // elaborate away, so only the needed adders remain.
  always_comb begin
    w_sum = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (FACTOR_BITS[i]) begin
        w_sum = w_sum + (PW'(i_data) << i);
      end
    end
  end

  assign o_prod = w_sum;

endmodule

// File: rtl/sync_counter.sv
// ---------------------------------------------------------------------------
// sync_counter
// Registers data * FACTOR every rising fast_clk edge (latency 1, one new
// operand per cycle). The result is wrapped to WIDTH bits by default;
// defining SYNC_COUNTER_SAT_EN clamps any overflowing product to all ones.
// Ports:
//   fast_clk  input             sole clock, rising edge
//   rst_n     input             asynchronous active-low reset, clears output
//   data      input  [WIDTH-1:0] unsigned operand
//   multiply  output [WIDTH-1:0] registered (wrapped/saturated) product
// Macro: SYNC_COUNTER_SAT_EN (optional saturation instead of wrap)
// ---------------------------------------------------------------------------
module sync_counter
  import sync_counter_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int FACTOR = FACTOR_DEF
) (
  input  logic             fast_clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] multiply
);

  localparam int PW = prod_width(WIDTH);

  logic [PW-1:0]    w_prod_p0;
  logic [WIDTH-1:0] w_next_p0;
  logic [WIDTH-1:0] r_mult_p1;

  const_mult #(
    .WIDTH  (WIDTH),
    .FACTOR (FACTOR)
  ) u_const_mult (
    .i_data (data),
    .o_prod (w_prod_p0)
  );

`ifdef SYNC_COUNTER_SAT_EN
  // Any set bit above the low WIDTH bits means the product overflowed.
  function automatic logic [WIDTH-1:0] sat_prod(input logic [PW-1:0] p);
    if (|p[PW-1:WIDTH]) begin
      return '1;
    end
    return WIDTH'(p);
  endfunction

  assign w_next_p0 = sat_prod(w_prod_p0);
`else
  function automatic logic [WIDTH-1:0] wrap_prod(input logic [PW-1:0] p);
    return WIDTH'(p);
  endfunction

  assign w_next_p0 = wrap_prod(w_prod_p0);
`endif

  // ---- stage p0 -> p1: output register ----
  always_ff @(posedge fast_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mult_p1 <= '0;
    end else begin
      r_mult_p1 <= w_next_p0;
    end
  end

  assign multiply = r_mult_p1;

endmodule

// File: tb/tb_sync_counter.sv
// ---------------------------------------------------------------------------
// tb_sync_counter
// Self-checking bench for sync_counter. Several instances with different
// FACTOR values share clock, reset and data. Inputs change and outputs are
// sampled on the falling edge of fast_clk.
// ---------------------------------------------------------------------------
module tb_sync_counter;

  logic       fast_clk = 1'b0;
  logic       rst_n    = 1'b0;
  logic [3:0] data     = 4'hF;
  logic [3:0] m2, m0, m1, m15, m3;

  int errors = 0;
  int checks = 0;

  always #5 fast_clk = ~fast_clk;

  sync_counter #(.WIDTH(4), .FACTOR(2))  dut   (.fast_clk(fast_clk), .rst_n(rst_n), .data(data), .multiply(m2));
  sync_counter #(.WIDTH(4), .FACTOR(0))  dut0  (.fast_clk(fast_clk), .rst_n(rst_n), .data(data), .multiply(m0));
  sync_counter #(.WIDTH(4), .FACTOR(1))  dut1  (.fast_clk(fast_clk), .rst_n(rst_n), .data(data), .multiply(m1));
  sync_counter #(.WIDTH(4), .FACTOR(15)) dut15 (.fast_clk(fast_clk), .rst_n(rst_n), .data(data), .multiply(m15));
  sync_counter #(.WIDTH(4), .FACTOR(3))  dut3  (.fast_clk(fast_clk), .rst_n(rst_n), .data(data), .multiply(m3));

  // Reference: plain integer product, then wrap or clamp to 4 bits.
  function automatic logic [3:0] ref_mult(input int d, input int f);
    int p;
    p = d * f;
`ifdef SYNC_COUNTER_SAT_EN
    if (p > 15) p = 15;
    return 4'(p);
`else
    return 4'(p % 16);
`endif
  endfunction

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input int d);
    check({tag, " f2"},  m2,  ref_mult(d, 2));
    check({tag, " f0"},  m0,  ref_mult(d, 0));
    check({tag, " f1"},  m1,  ref_mult(d, 1));
    check({tag, " f15"}, m15, ref_mult(d, 15));
    check({tag, " f3"},  m3,  ref_mult(d, 3));
  endtask

  typedef struct {
    logic [3:0] d;
    logic [3:0] e_wrap;  // FACTOR = 2, wrapping
    logic [3:0] e_sat;   // FACTOR = 2, saturating
  } vec_t;

  vec_t sweep [16];

  typedef struct {
    logic [3:0] d;
    logic [3:0] e3;      // FACTOR = 3, wrapping
  } lat_t;

  lat_t lat [3];

  initial begin
    logic [3:0] prev_d;
    logic       loaded;
    logic [3:0] held;

    sweep[0]  = '{4'd0,  4'd0,  4'd0};
    sweep[1]  = '{4'd1,  4'd2,  4'd2};
    sweep[2]  = '{4'd2,  4'd4,  4'd4};
    sweep[3]  = '{4'd3,  4'd6,  4'd6};
    sweep[4]  = '{4'd4,  4'd8,  4'd8};
    sweep[5]  = '{4'd5,  4'd10, 4'd10};
    sweep[6]  = '{4'd6,  4'd12, 4'd12};
    sweep[7]  = '{4'd7,  4'd14, 4'd14};
    sweep[8]  = '{4'd8,  4'd0,  4'd15};
    sweep[9]  = '{4'd9,  4'd2,  4'd15};
    sweep[10] = '{4'd10, 4'd4,  4'd15};
    sweep[11] = '{4'd11, 4'd6,  4'd15};
    sweep[12] = '{4'd12, 4'd8,  4'd15};
    sweep[13] = '{4'd13, 4'd10, 4'd15};
    sweep[14] = '{4'd14, 4'd12, 4'd15};
    sweep[15] = '{4'd15, 4'd14, 4'd15};

    lat[0] = '{4'd4, 4'd12};
    lat[1] = '{4'd9, 4'd11};
    lat[2] = '{4'd1, 4'd3};

    // Reset is asynchronous: output is 0 before any clock edge.
    #2;
    check("reset f2",  m2,  4'd0);
    check("reset f1",  m1,  4'd0);
    check("reset f15", m15, 4'd0);

    // Release between edges, first edge loads data present there.
    @(negedge fast_clk);
    rst_n = 1'b1;
    data  = 4'd3;
    @(negedge fast_clk);
    check("post-reset f2", m2, 4'd6);
    check_all("post-reset", 3);

    // Sweep, one value per cycle, driven on the falling edge.
    for (int i = 0; i <= 16; i++) begin
      if (i > 0) begin
`ifdef SYNC_COUNTER_SAT_EN
        check($sformatf("sweep d=%0d", sweep[i-1].d), m2, sweep[i-1].e_sat);
`else
        check($sformatf("sweep d=%0d", sweep[i-1].d), m2, sweep[i-1].e_wrap);
`endif
        check_all($sformatf("sweep-all d=%0d", sweep[i-1].d), int'(sweep[i-1].d));
      end
      if (i < 16) data = sweep[i].d;
      @(negedge fast_clk);
    end

    // Overflow boundary values for FACTOR = 2 and FACTOR = 15.
    data = 4'd7;  @(negedge fast_clk); check("ovf d=7",  m2, 4'd14);
    data = 4'd8;  @(negedge fast_clk);
`ifdef SYNC_COUNTER_SAT_EN
    check("ovf d=8", m2, 4'd15);
`else
    check("ovf d=8", m2, 4'd0);
`endif
    data = 4'd15; @(negedge fast_clk);
`ifdef SYNC_COUNTER_SAT_EN
    check("ovf d=15", m2, 4'd15);
    check("f15 d=15", m15, 4'd15);
`else
    check("ovf d=15", m2, 4'd14);
    check("f15 d=15", m15, 4'd1);
`endif
    check("f1 echo d=15", m1, 4'd15);
    check("f0 d=15", m0, 4'd0);

    // Latency sequence with FACTOR = 3 (in-range products only here
    // after the wrap; compare against the wrap column).
    for (int i = 0; i <= 3; i++) begin
      if (i > 0) begin
`ifdef SYNC_COUNTER_SAT_EN
        check($sformatf("lat%0d f3", i-1), m3, ref_mult(int'(lat[i-1].d), 3));
`else
        check($sformatf("lat%0d f3", i-1), m3, lat[i-1].e3);
`endif
      end
      if (i < 3) data = lat[i].d;
      @(negedge fast_clk);
    end

    // Mid-stream reset: pulse low between edges, clears immediately.
    data = 4'd5;
    @(negedge fast_clk);
    check("stream d=5", m2, 4'd10);
    #2 rst_n = 1'b0;
    #1;
    check("midrst f2", m2, 4'd0);
    check("midrst f3", m3, 4'd0);
    check("midrst f1", m1, 4'd0);
    #1 rst_n = 1'b1;
    @(negedge fast_clk);
    check("after midrst f2", m2, 4'd10);

    // Randomized stream against the reference model; also confirm the
    // output does not move when data changes away from the rising edge.
    prev_d = data;
    loaded = 1'b1;
    for (int n = 0; n < 200; n++) begin
      if (n % 50 == 49) begin
        rst_n = 1'b0;
        #1;
        loaded = 1'b0;
        check("rand rst f2", m2, 4'd0);
        rst_n = 1'b1;
      end
      held = m2;
      data = 4'($urandom_range(0, 15));
      #1;
      check("no comb path", m2, held);
      @(negedge fast_clk);
      prev_d = data;
      loaded = 1'b1;
      if (loaded) check_all("rand", int'(prev_d));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/sync_counter.md
SYNC_COUNTER -- requirements
Module: sync_counter

Interface
REQ-001 Parameter WIDTH, default 4: width of data and multiply.
REQ-002 Parameter FACTOR, default 2: unsigned constant multiplier, range 0..2^WIDTH-1.
REQ-003 Port fast_clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port data  input  WIDTH  unsigned operand, sampled every rising fast_clk edge.
REQ-006 Port multiply  output  WIDTH  registered product of data and FACTOR.
REQ-007 The block SHALL have one clock (fast_clk) and an asynchronous active-low reset (rst_n); no other clocks, enables or handshakes.

Function
REQ-008 On each rising fast_clk edge with rst_n high, the block SHALL compute the full-precision product P = data * FACTOR (2*WIDTH bits) and register it.
REQ-009 multiply SHALL equal the wrapped product P mod 2^WIDTH (low WIDTH bits) of the data sampled on the previous rising edge; latency is exactly 1 cycle.
REQ-010 multiply SHALL be driven only from a flop; there is no combinational path from data to multiply.
REQ-011 The block SHALL accept a new data value every cycle (throughput 1 per cycle, no stalls).
REQ-012 Data changing on the falling edge SHALL be captured on the next rising edge without glitching multiply.
REQ-013 With FACTOR = 0, multiply SHALL remain 0 at all times.
REQ-014 With FACTOR = 1, multiply SHALL equal data delayed by one cycle.
REQ-015 Overflow (P >= 2^WIDTH) SHALL wrap modulo 2^WIDTH unless the saturation feature is compiled in.

Reset
REQ-016 While rst_n is low, multiply SHALL be 0, asynchronously and independent of fast_clk.
REQ-017 After rst_n deasserts, the first rising edge SHALL load the product of the data present at that edge.
REQ-018 Reset asserted mid-stream SHALL clear multiply immediately and discard the in-flight product.

Configuration
REQ-019 Macro SYNC_COUNTER_SAT_EN: when defined, any P >= 2^WIDTH SHALL make multiply all ones (2^WIDTH-1) instead of wrapping.
REQ-020 When SYNC_COUNTER_SAT_EN is not defined, the block SHALL wrap per REQ-009, and no saturation logic SHALL be present.

Structure
REQ-021 Package sync_counter_pkg SHALL hold WIDTH_DEF = 4, FACTOR_DEF = 2 and the product-width localparam rule (2*WIDTH).
REQ-022 The multiply SHALL live in one combinational sub-module const_mult (data in, P out, WIDTH/FACTOR parameters), built as shift-and-add over the set bits of FACTOR.
REQ-023 The top level SHALL hold only the optional saturation/truncation and the output register.

Verification
REQ-024 Reset: rst_n = 0 with data = 4'b1111 -> multiply = 0 with no clock edge needed; deassert, next edge with data = 3 -> multiply = 6.
REQ-025 Sweep (FACTOR = 2, wrap): data = 0..15, one value per cycle changed on the falling edge -> multiply one cycle later = 0,2,4,...,14,0,2,...,14.
REQ-026 Overflow (SYNC_COUNTER_SAT_EN defined, FACTOR = 2): data = 7 -> 14; data = 8 -> 15; data = 15 -> 15.
REQ-027 Mid-stream reset: data = 5 streaming, pulse rst_n low between edges -> multiply = 0 at once; next edge after release -> 10.
REQ-028 Corner FACTOR values: FACTOR = 0 -> always 0; FACTOR = 1 -> echo data; FACTOR = 15, data = 15 -> 1 (wrap) or 15 (saturate).
REQ-029 Latency check: data goes 4 -> 9 -> 1 on consecutive cycles (FACTOR = 3, wrap) -> multiply 12, 11, 3 on the three following cycles.
